bitwise_pipe: RTL

Parametrised, pipelined successor to the fixed 16-bit NAND bank. Applies one of eight bitwise operations to two WIDTH-bit operands per accepted transaction, with an optional running accumulator as the B operand. Results are buffered in a two-entry output queue behind a valid/ready handshake. It sits between operand sources (register file, datapath muxes) and ALU/writeback consumers that may stall.

---
 rtl/bitwise_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/bitwise_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bitwise_pipe
// Purpose  : Pipelined bitwise unit. Each accepted transaction applies one
//            of eight bitwise operations to A and B, where B is either the
//            `b` port or a running accumulator. Results go into a two-entry
//            output queue that sits behind a valid/ready handshake.
// Revision : 1.0 - initial release
//
// Parameters:
//   WIDTH      operand and result width in bits (>= 1)
//
// Ports:
//   clk        single clock; all state updates on the rising edge
//   rst_n      asynchronous, active-low reset
//   in_valid   an operand transaction is offered
//   in_ready   the block can accept a transaction (count < 2)
//   op         operation select, sampled on accept
//   acc_sel    1: the accumulator replaces `b` as operand B
//   a, b       operands
//   out_valid  the queue head holds a result
//   out_ready  the consumer takes the head this cycle
//   y          queue-head result (zero when the queue is empty)
//   zr, ng     head-is-zero / head-MSB flags
//              (present only when BITWISE_PIPE_FLAGS_EN is defined)
//
// Build option:
//   BITWISE_PIPE_FLAGS_EN  define it to add the zr/ng flag outputs
// ============================================================================
module bitwise_pipe #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic             acc_sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y
`ifdef BITWISE_PIPE_FLAGS_EN
  ,
  output logic             zr,
  output logic             ng
`endif
);

  localparam logic [2:0] c_OP_NAND = 3'b000;
  localparam logic [2:0] c_OP_AND  = 3'b001;
  localparam logic [2:0] c_OP_OR   = 3'b010;
  localparam logic [2:0] c_OP_NOR  = 3'b011;
  localparam logic [2:0] c_OP_XOR  = 3'b100;
  localparam logic [2:0] c_OP_XNOR = 3'b101;
  localparam logic [2:0] c_OP_NOTA = 3'b110;
  localparam logic [2:0] c_OP_PASS = 3'b111;

  localparam logic [1:0] c_COUNT_EMPTY = 2'd0;
  localparam logic [1:0] c_COUNT_ONE   = 2'd1;
  localparam logic [1:0] c_COUNT_FULL  = 2'd2;

  // Two-entry queue held as head (r_q0) and tail (r_q1); r_count is the
  // occupancy.
  logic [1:0]       r_count;
  logic [WIDTH-1:0] r_q0;
  logic [WIDTH-1:0] r_q1;
  logic [WIDTH-1:0] r_acc;

  logic             w_accept;
  logic             w_pop;
  logic [WIDTH-1:0] w_opb;
  logic [WIDTH-1:0] w_result;

  // Handshake outputs are decoded from r_count alone. in_ready therefore
  // never depends on out_ready, and a full queue stalls the input side for
  // the cycle in which it drains.
  assign in_ready  = (r_count != c_COUNT_FULL);
  assign out_valid = (r_count != c_COUNT_EMPTY);
  assign y         = out_valid ? r_q0 : '0;

`ifdef BITWISE_PIPE_FLAGS_EN
  // When the queue is empty, y is forced to zero, so zr=1 and ng=0 follow
  // without any extra logic.
  assign zr = (y == '0);
  assign ng = y[WIDTH-1];
`endif

  assign w_accept = in_valid && in_ready;
  assign w_pop    = out_valid && out_ready;
  assign w_opb    = acc_sel ? r_acc : b;

  always_comb begin
    w_result = '0;
    unique case (op)
      c_OP_NAND: w_result = ~(a & w_opb);
      c_OP_AND:  w_result = a & w_opb;
      c_OP_OR:   w_result = a | w_opb;
      c_OP_NOR:  w_result = ~(a | w_opb);
      c_OP_XOR:  w_result = a ^ w_opb;
      c_OP_XNOR: w_result = ~(a ^ w_opb);
      c_OP_NOTA: w_result = ~a;
      c_OP_PASS: w_result = a;
      default:   w_result = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= c_COUNT_EMPTY;
      r_q0    <= '0;
      r_q1    <= '0;
      r_acc   <= '0;
    end else begin
      if (w_accept) begin
        r_acc <= w_result;
      end

      if (w_accept && w_pop) begin
        // An accept implies count < 2, and a pop implies count > 0, so
        // count is 1 here. The new result replaces the departing head.
        r_q0 <= w_result;
      end else if (w_accept) begin
        if (r_count == c_COUNT_EMPTY) begin
          r_q0 <= w_result;
        end else begin
          r_q1 <= w_result;
        end
        r_count <= r_count + c_COUNT_ONE;
      end else if (w_pop) begin
        r_q0    <= r_q1;
        r_count <= r_count - c_COUNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
